// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor short-circuits straight to DONE with a saturated quotient.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] part;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] work_next;

  // The dividend register shifts out its MSB each step and takes in the new
  // quotient bit, so after WIDTH steps it holds the full quotient. When the
  // subtract happens the result is below the divisor, so WIDTH bits suffice.
  always_comb begin
    shifted   = {part, work[WIDTH-1]};
    fits      = (shifted >= {1'b0, dsr});
    part_next = fits ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
    work_next = {work[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      work        <= '0;
      dsr         <= '0;
      part        <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
              work  <= dividend;
              dsr   <= divisor;
              part  <= '0;
              count <= '0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        RUN: begin
          part  <= part_next;
          work  <= work_next;
          count <= count + 1'b1;
          // Results are published straight from the final step's values.
          if (count == LAST_STEP) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= work_next;
            remainder   <= part_next;
            div_by_zero <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed scenarios followed
// by randomized back-to-back operations checked against an arithmetic model.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [7:0] prev_q;
  logic [7:0] prev_r;
  logic       prev_dz;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the saturated result for b == 0.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  // Presents operands with start for exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done; outputs must hold meanwhile.
  task automatic waitDone(output int lat, output int busy_cnt, input bit check_hold);
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (check_hold) begin
        checkOutput("hold_quotient", quotient, prev_q);
        checkOutput("hold_remainder", remainder, prev_r);
        checkOutput("hold_div_by_zero", div_by_zero, prev_dz);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) checkOutput("done_timeout", done, 1'b1);
  endtask

  task automatic checkResult(input logic [7:0] a, input logic [7:0] b,
                             input int lat, input int busy_cnt, input int exp_lat);
    logic [7:0] eq, er;
    logic       edz;
    model(a, b, eq, er, edz);
    checkOutput("latency", lat, exp_lat);
    checkOutput("busy_cycles", busy_cnt, (b == 8'd0) ? 0 : 8);
    checkOutput("quotient", quotient, eq);
    checkOutput("remainder", remainder, er);
    checkOutput("div_by_zero", div_by_zero, edz);
    if (b != 8'd0) begin
      checkOutput("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      checkOutput("rem_lt_divisor", 32'(remainder < b), 32'd1);
    end
    prev_q = eq;
    prev_r = er;
    prev_dz = edz;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_quotient"}, quotient, 8'd0);
    checkOutput({tag, "_remainder"}, remainder, 8'd0);
    checkOutput({tag, "_div_by_zero"}, div_by_zero, 1'b0);
  endtask

  initial begin
    int lat, bcnt, lat2, dones;
    logic [7:0] a, b;
    int sel;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    #1;
    checkZeroOutputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100/7, then back-to-back 81/4 issued during the done cycle
    applyStimulus(8'd100, 8'd7);
    waitDone(lat, bcnt, 1'b1);
    checkResult(8'd100, 8'd7, lat, bcnt, 8);
    applyStimulus(8'd81, 8'd4);
    waitDone(lat, bcnt, 1'b1);
    checkResult(8'd81, 8'd4, lat, bcnt, 8);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", done, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);

    applyStimulus(8'd255, 8'd1);   waitDone(lat, bcnt, 1'b1); checkResult(8'd255, 8'd1, lat, bcnt, 8);
    applyStimulus(8'd3, 8'd10);    waitDone(lat, bcnt, 1'b1); checkResult(8'd3, 8'd10, lat, bcnt, 8);
    applyStimulus(8'd255, 8'd255); waitDone(lat, bcnt, 1'b1); checkResult(8'd255, 8'd255, lat, bcnt, 8);
    @(posedge clk);
    #1;

    // Zero divisor completes immediately without ever raising busy
    applyStimulus(8'd5, 8'd0);
    waitDone(lat, bcnt, 1'b1);
    checkResult(8'd5, 8'd0, lat, bcnt, 0);
    @(posedge clk);
    #1;
    checkOutput("dz_done_one_cycle", done, 1'b0);

    // start while busy must be ignored
    applyStimulus(8'd200, 8'd9);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(8'd50, 8'd5);
    waitDone(lat2, bcnt, 1'b1);
    checkResult(8'd200, 8'd9, 4 + lat2, 8, 8);

    // Asynchronous reset mid-operation aborts it
    @(posedge clk);
    #1;
    applyStimulus(8'd200, 8'd9);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkZeroOutputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prev_q = '0; prev_r = '0; prev_dz = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    checkOutput("no_done_after_abort", dones, 0);
    checkZeroOutputs("after_abort");

    // First operation after reset behaves normally
    applyStimulus(8'd100, 8'd7);
    waitDone(lat, bcnt, 1'b1);
    checkResult(8'd100, 8'd7, lat, bcnt, 8);

    // Randomized back-to-back operations, zero divisors included
    for (int n = 0; n < 10000; n++) begin
      a = 8'($urandom_range(255, 0));
      sel = $urandom_range(4, 0);
      if (sel < 2)       b = 8'd0;
      else if (sel == 2) b = 8'($urandom_range(15, 1));
      else               b = 8'($urandom_range(255, 1));
      applyStimulus(a, b);
      waitDone(lat, bcnt, 1'b1);
      checkResult(a, b, lat, bcnt, (b == 8'd0) ? 0 : 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled on the rising edge.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned numerator; sampled only when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned denominator; sampled only when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results are valid in that cycle.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered flag; set when the last completed operation had divisor 0.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE; it SHALL enter IDLE on reset.
REQ-013 SHALL accept start only when busy=0, i.e. in IDLE or DONE, and SHALL capture dividend and divisor on the accepting edge (cycle 0).
REQ-014 SHALL ignore start while busy=1, with no effect on state, operands or outputs.
REQ-015 SHALL, when divisor≠0, go to RUN and perform one unsigned restoring shift-subtract step per cycle for exactly WIDTH cycles (cycles 1..WIDTH), MSB of dividend first.
REQ-016 Each step SHALL shift the partial remainder left by one, bringing in the next dividend bit; if the result ≥ divisor, it SHALL subtract divisor and set the quotient bit to 1, else set the quotient bit to 0; the compare SHALL use WIDTH+1 bits so that no overflow is possible.
REQ-017 SHALL enter DONE in cycle WIDTH+1 and, on that edge, update quotient, remainder and div_by_zero=0; done=1 and busy=0 SHALL hold for exactly that cycle.
REQ-018 SHALL, when divisor=0, skip RUN and enter DONE in cycle 1 with quotient = all ones, remainder = dividend and div_by_zero=1.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-020 DONE SHALL return to IDLE on the next edge unless start=1, in which case it SHALL accept the new operation directly (back-to-back operation, with no idle cycle).
REQ-021 quotient, remainder and div_by_zero SHALL hold their last completed values until the next DONE entry, including during a subsequent RUN.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for all divisor≠0.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, done=0, quotient=0, remainder=0 and div_by_zero=0, and clear the internal operand and partial registers.
REQ-024 Reset asserted mid-operation SHALL abort that operation: no done pulse SHALL follow, and results SHALL read 0.
REQ-025 The first accepted start after rst_n deasserts SHALL behave exactly as REQ-013.

Verification
REQ-026 WIDTH=8, 100/7 -> busy cycles 1..8, done in cycle 9 with quotient=14, remainder=2, div_by_zero=0.
REQ-027 255/1 -> quotient=255, remainder=0; 3/10 -> quotient=0, remainder=3; 255/255 -> quotient=1, remainder=0.
REQ-028 5/0 -> done in cycle 1 with quotient=255, remainder=5, div_by_zero=1, and busy never asserted.
REQ-029 Start 200/9, then start=1 with 50/5 in cycle 4 -> the second start is ignored; done in cycle 9 with quotient=22, remainder=2.
REQ-030 Start 200/9, then rst_n=0 in cycle 5 -> all outputs 0 immediately, and no done pulse appears within 20 cycles.
REQ-031 start=1 during the done cycle of 100/7 with new operands 81/4 -> the next done occurs 9 cycles later with quotient=20, remainder=1; the outputs hold 14/2 in between.
REQ-032 The bench SHALL run 10000 random WIDTH=8 operand pairs, including divisor 0, and check REQ-022 and REQ-018 against a reference model.
